// File: rtl/wishbone_arbiter_if.sv
// ---------------------------------------------------------------------------
// wishbone_arbiter_if
//
// Purpose: bundles every bus signal of the N-master / 1-slave Wishbone
// arbiter so the arbiter and its environment connect through one port.
// Per-master fields are flat-packed, with master k at slice k.
//
// Parameters:
//   NUM_MASTERS  number of requesting masters (2..8)
//   TAGSIZE      width of the tga/tgd/tgc tag fields
//
// Signal summary (direction as seen by the arbiter):
//   m_cyc_i/m_stb_i/m_we_i       in   per-master cycle/strobe/write enable
//   m_sel_i                      in   per-master byte selects (4 each)
//   m_adr_i/m_dat_i              in   per-master address/write data (32 each)
//   m_tga_i/m_tgd_i/m_tgc_i      in   per-master tags (TAGSIZE each)
//   m_dat_o/m_tgd_o              out  read data/tag broadcast to all masters
//   m_ack_o/m_err_o/m_rty_o      out  per-master responses
//   s_cyc_o/s_stb_o/s_we_o       out  slave cycle/strobe/write enable
//   s_sel_o/s_adr_o/s_dat_o      out  slave byte select/address/write data
//   s_tga_o/s_tgd_o/s_tgc_o      out  slave tags
//   s_dat_i/s_tgd_i              in   slave read data/tag
//   s_ack_i/s_err_i/s_rty_i      in   slave responses
//   grant_o                      out  one-hot current grant, zero when idle
//
// Modports:
//   slave   the arbiter itself; it is the slave of all the masters
//   master  the environment: the masters plus the downstream slave
// ---------------------------------------------------------------------------
interface wishbone_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int TAGSIZE     = 2
);

  logic [NUM_MASTERS-1:0]         m_cyc_i;
  logic [NUM_MASTERS-1:0]         m_stb_i;
  logic [NUM_MASTERS-1:0]         m_we_i;
  logic [4*NUM_MASTERS-1:0]       m_sel_i;
  logic [32*NUM_MASTERS-1:0]      m_adr_i;
  logic [32*NUM_MASTERS-1:0]      m_dat_i;
  logic [TAGSIZE*NUM_MASTERS-1:0] m_tga_i;
  logic [TAGSIZE*NUM_MASTERS-1:0] m_tgd_i;
  logic [TAGSIZE*NUM_MASTERS-1:0] m_tgc_i;

  logic [31:0]                    m_dat_o;
  logic [TAGSIZE-1:0]             m_tgd_o;
  logic [NUM_MASTERS-1:0]         m_ack_o;
  logic [NUM_MASTERS-1:0]         m_err_o;
  logic [NUM_MASTERS-1:0]         m_rty_o;

  logic                           s_cyc_o;
  logic                           s_stb_o;
  logic                           s_we_o;
  logic [3:0]                     s_sel_o;
  logic [31:0]                    s_adr_o;
  logic [31:0]                    s_dat_o;
  logic [TAGSIZE-1:0]             s_tga_o;
  logic [TAGSIZE-1:0]             s_tgd_o;
  logic [TAGSIZE-1:0]             s_tgc_o;

  logic [31:0]                    s_dat_i;
  logic [TAGSIZE-1:0]             s_tgd_i;
  logic                           s_ack_i;
  logic                           s_err_i;
  logic                           s_rty_i;

  logic [NUM_MASTERS-1:0]         grant_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  m_tga_i, m_tgd_i, m_tgc_i,
    output m_dat_o, m_tgd_o, m_ack_o, m_err_o, m_rty_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_tga_o, s_tgd_o, s_tgc_o,
    input  s_dat_i, s_tgd_i, s_ack_i, s_err_i, s_rty_i,
    output grant_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output m_tga_i, m_tgd_i, m_tgc_i,
    input  m_dat_o, m_tgd_o, m_ack_o, m_err_o, m_rty_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_tga_o, s_tgd_o, s_tgc_o,
    output s_dat_i, s_tgd_i, s_ack_i, s_err_i, s_rty_i,
    input  grant_o
  );

endinterface

// File: rtl/wishbone_arbiter.sv
// ---------------------------------------------------------------------------
// wishbone_arbiter
//
// Purpose: round-robin arbiter letting NUM_MASTERS Wishbone masters share a
// single slave. A master that raises m_cyc_i while the arbiter is idle is
// granted one cycle later and keeps the slave for as long as it holds
// m_cyc_i, so bursts are never broken up. Dropping m_cyc_i releases the
// grant; the arbiter then spends at least one cycle idle before granting
// again, and the master just served has the lowest priority next time.
//
// Parameters:
//   NUM_MASTERS     number of requesting masters (2..8)
//   TAGSIZE         width of the tag fields
//   TIMEOUT_CYCLES  unanswered strobe cycles tolerated before a local error
//
// Ports:
//   clk_i   clock, all logic on the rising edge
//   rstn_i  synchronous active-low reset
//   bus     wishbone_arbiter_if.slave, all master- and slave-side signals
//
// Optional feature (compile-time macro WB_ARB_TIMEOUT_EN):
//   defined   - a watchdog counts granted cycles where s_stb_o is high and
//               the slave gives no ack/err/rty. When it reaches
//               TIMEOUT_CYCLES the arbiter pulses m_err_o of the granted
//               master for one cycle and withholds s_stb_o in that cycle.
//   undefined - no watchdog; m_err_o only ever reflects s_err_i.
// ---------------------------------------------------------------------------
module wishbone_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TAGSIZE        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  wishbone_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  // Slice of the currently granted master
  logic               g_cyc;
  logic               g_stb;
  logic               g_we;
  logic [3:0]         g_sel;
  logic [31:0]        g_adr;
  logic [31:0]        g_dat;
  logic [TAGSIZE-1:0] g_tga;
  logic [TAGSIZE-1:0] g_tgd;
  logic [TAGSIZE-1:0] g_tgc;

  logic timeout_hit;

  // Round-robin search. Masters above last_grant are scanned first, then
  // the scan wraps to master 0 and ends at last_grant itself, so the most
  // recently served master always comes last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!pick_found && (k > int'(last_grant_q)) && bus.m_cyc_i[k]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(k);
      end
    end
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!pick_found && (k <= int'(last_grant_q)) && bus.m_cyc_i[k]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(k);
      end
    end
  end

  // Select the granted master's request fields
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_sel = '0;
    g_adr = '0;
    g_dat = '0;
    g_tga = '0;
    g_tgd = '0;
    g_tgc = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (gnt_idx_q == IDX_W'(k)) begin
        g_cyc = bus.m_cyc_i[k];
        g_stb = bus.m_stb_i[k];
        g_we  = bus.m_we_i[k];
        g_sel = bus.m_sel_i[k*4 +: 4];
        g_adr = bus.m_adr_i[k*32 +: 32];
        g_dat = bus.m_dat_i[k*32 +: 32];
        g_tga = bus.m_tga_i[k*TAGSIZE +: TAGSIZE];
        g_tgd = bus.m_tgd_i[k*TAGSIZE +: TAGSIZE];
        g_tgc = bus.m_tgc_i[k*TAGSIZE +: TAGSIZE];
      end
    end
  end

  // Next-state logic. The grant is held purely on the granted master's
  // m_cyc_i; other requests are not even looked at until we are back in
  // IDLE, which guarantees an idle cycle between consecutive grants.
  always_comb begin
    state_d      = state_q;
    gnt_idx_d    = gnt_idx_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d   = GRANT;
          gnt_idx_d = pick_idx;
        end
      end
      GRANT: begin
        if (!g_cyc) begin
          state_d      = IDLE;
          last_grant_d = gnt_idx_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. last_grant resets to the highest master so that
  // master 0 wins the first contention after reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      gnt_idx_q    <= '0;
      last_grant_q <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      state_q      <= state_d;
      gnt_idx_q    <= gnt_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            slave_resp;

  assign slave_resp = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;

  // Watchdog. The counter value equals the number of unanswered strobe
  // cycles seen so far in this grant; the cycle in which it holds
  // TIMEOUT_CYCLES is the one that reports the error.
  always_comb begin
    timeout_hit = (state_q == GRANT) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
    to_cnt_d    = to_cnt_q;
    if ((state_q != GRANT) || (state_d != GRANT) || timeout_hit || slave_resp) begin
      to_cnt_d = '0;
    end else if (g_stb) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // Read data and read tag are broadcast unconditionally
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.m_tgd_o = bus.s_tgd_i;

  // Output routing. Everything is zero in IDLE; in GRANT the slave sees the
  // granted master's slice and only that master sees the slave's response.
  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_sel_o = '0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_tga_o = '0;
    bus.s_tgd_o = '0;
    bus.s_tgc_o = '0;
    bus.grant_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_rty_o = '0;
    if (state_q == GRANT) begin
      bus.s_cyc_o = g_cyc;
      bus.s_stb_o = g_stb & ~timeout_hit;
      bus.s_we_o  = g_we;
      bus.s_sel_o = g_sel;
      bus.s_adr_o = g_adr;
      bus.s_dat_o = g_dat;
      bus.s_tga_o = g_tga;
      bus.s_tgd_o = g_tgd;
      bus.s_tgc_o = g_tgc;
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (gnt_idx_q == IDX_W'(k)) begin
          bus.grant_o[k] = 1'b1;
          bus.m_ack_o[k] = bus.s_ack_i;
          bus.m_err_o[k] = bus.s_err_i | timeout_hit;
          bus.m_rty_o[k] = bus.s_rty_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wishbone_arbiter
//
// Directed bench for wishbone_arbiter with two masters. Inputs change 1 ns
// after each rising edge and outputs are sampled 4 ns after the edge.
// Expected values are written out by hand for every cycle of interest.
// With WB_ARB_TIMEOUT_EN defined the watchdog error is expected on the
// sixteenth cycle after the first unanswered strobe; otherwise no error
// may ever appear.
// ---------------------------------------------------------------------------
module tb_wishbone_arbiter;

  localparam int NM = 2;
  localparam int TS = 2;
  localparam int TO = 16;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  wishbone_arbiter_if #(.NUM_MASTERS(NM), .TAGSIZE(TS)) bus ();

  wishbone_arbiter #(
    .NUM_MASTERS   (NM),
    .TAGSIZE       (TS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  // Free-running clock, 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive request lines and the slave response {rty, err, ack}
  task automatic applyStimulus(input logic [1:0] cyc, input logic [1:0] stb,
                               input logic [2:0] resp);
    bus.m_cyc_i = cyc;
    bus.m_stb_i = stb;
    bus.s_ack_i = resp[0];
    bus.s_err_i = resp[1];
    bus.s_rty_i = resp[2];
  endtask

  // Load one master's request fields
  task automatic setMaster(input int k, input logic we, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] dat,
                           input logic [1:0] tga, input logic [1:0] tgd,
                           input logic [1:0] tgc);
    bus.m_we_i[k]          = we;
    bus.m_sel_i[k*4 +: 4]  = sel;
    bus.m_adr_i[k*32 +: 32] = adr;
    bus.m_dat_i[k*32 +: 32] = dat;
    bus.m_tga_i[k*2 +: 2]  = tga;
    bus.m_tgd_i[k*2 +: 2]  = tgd;
    bus.m_tgc_i[k*2 +: 2]  = tgc;
  endtask

  // Advance to just after the next rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    bus.m_we_i  = '0;
    bus.m_sel_i = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_tga_i = '0;
    bus.m_tgd_i = '0;
    bus.m_tgc_i = '0;
    setMaster(0, 1'b0, 4'h3, 32'hA000_0004, 32'h1111_2222, 2'b01, 2'b10, 2'b11);
    setMaster(1, 1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF, 2'b10, 2'b11, 2'b01);
    bus.s_dat_i = 32'h1234_5678;
    bus.s_tgd_i = 2'b10;
    applyStimulus(2'b11, 2'b11, 3'b000);

    // Reset held two cycles with both masters requesting
    cycle();
    #3;
    checkOutput("rst_grant", bus.grant_o, 64'h0);
    checkOutput("rst_scyc", bus.s_cyc_o, 64'h0);
    checkOutput("dat_passthru", bus.m_dat_o, 64'h1234_5678);
    checkOutput("tgd_passthru", bus.m_tgd_o, 64'h2);
    cycle();
    rstn = 1'b1;
    applyStimulus(2'b11, 2'b11, 3'b001);
    #3;
    checkOutput("rel_idle_grant", bus.grant_o, 64'h0);
    checkOutput("idle_ack", bus.m_ack_o, 64'h0);
    checkOutput("idle_sstb", bus.s_stb_o, 64'h0);

    // Round robin: master 0 first, then 1, then back to 0
    cycle();
    applyStimulus(2'b11, 2'b11, 3'b001);
    #3;
    checkOutput("rr_g0", bus.grant_o, 64'h1);
    checkOutput("rr_ack0", bus.m_ack_o, 64'h1);
    checkOutput("rr_adr0", bus.s_adr_o, 64'hA000_0004);
    checkOutput("rr_sel0", bus.s_sel_o, 64'h3);
    cycle();
    applyStimulus(2'b10, 2'b10, 3'b000);
    #3;
    checkOutput("rr_drop_grant0", bus.grant_o, 64'h1);
    checkOutput("rr_drop_scyc0", bus.s_cyc_o, 64'h0);
    cycle();
    applyStimulus(2'b11, 2'b11, 3'b000);
    #3;
    checkOutput("rr_idle1", bus.grant_o, 64'h0);
    cycle();
    applyStimulus(2'b11, 2'b11, 3'b001);
    #3;
    checkOutput("rr_g1", bus.grant_o, 64'h2);
    checkOutput("rr_ack1", bus.m_ack_o, 64'h2);
    cycle();
    applyStimulus(2'b01, 2'b01, 3'b000);
    #3;
    checkOutput("rr_drop_scyc1", bus.s_cyc_o, 64'h0);
    cycle();
    applyStimulus(2'b11, 2'b11, 3'b000);
    #3;
    checkOutput("rr_idle2", bus.grant_o, 64'h0);
    cycle();
    applyStimulus(2'b10, 2'b10, 3'b000);
    #3;
    checkOutput("rr_g0_again", bus.grant_o, 64'h1);
    checkOutput("rr_release", bus.s_cyc_o, 64'h0);

    // Burst by master 1 while master 0 keeps requesting
    cycle();
    applyStimulus(2'b10, 2'b10, 3'b000);
    #3;
    checkOutput("burst_idle", bus.grant_o, 64'h0);
    for (int b = 0; b < 4; b++) begin
      cycle();
      applyStimulus(2'b11, 2'b11, 3'b001);
      #3;
      checkOutput("burst_grant", bus.grant_o, 64'h2);
      checkOutput("burst_ack", bus.m_ack_o, 64'h2);
    end
    checkOutput("route_adr", bus.s_adr_o, 64'h0000_1000);
    checkOutput("route_dat", bus.s_dat_o, 64'hDEAD_BEEF);
    checkOutput("route_sel", bus.s_sel_o, 64'hF);
    checkOutput("route_we", bus.s_we_o, 64'h1);
    checkOutput("route_tags", {bus.s_tga_o, bus.s_tgd_o, bus.s_tgc_o}, 64'h2D);

    // Retry and error responses go to master 1 only, grant retained
    cycle();
    applyStimulus(2'b11, 2'b11, 3'b100);
    #3;
    checkOutput("rty_route", bus.m_rty_o, 64'h2);
    checkOutput("rty_no_ack", bus.m_ack_o, 64'h0);
    cycle();
    applyStimulus(2'b11, 2'b11, 3'b010);
    #3;
    checkOutput("rty_hold", bus.grant_o, 64'h2);
    checkOutput("err_route", bus.m_err_o, 64'h2);
    checkOutput("err_no_rty", bus.m_rty_o, 64'h0);
    cycle();
    applyStimulus(2'b01, 2'b01, 3'b000);
    #3;
    checkOutput("burst_release", bus.s_cyc_o, 64'h0);
    cycle();
    applyStimulus(2'b01, 2'b01, 3'b000);
    #3;
    checkOutput("post_burst_idle", bus.grant_o, 64'h0);
    cycle();
    applyStimulus(2'b00, 2'b00, 3'b000);
    #3;
    checkOutput("m0_after_burst", bus.grant_o, 64'h1);
    cycle();
    applyStimulus(2'b00, 2'b00, 3'b000);
    cycle();
    #3;
    checkOutput("idle_no_req", bus.grant_o, 64'h0);

    // Slave never answers master 0
    applyStimulus(2'b01, 2'b01, 3'b000);
    #3;
    checkOutput("to_idle", bus.grant_o, 64'h0);
    for (int i = 0; i <= 20; i++) begin
      cycle();
      applyStimulus(2'b01, 2'b01, 3'b000);
      #3;
`ifdef WB_ARB_TIMEOUT_EN
      checkOutput($sformatf("to_err_%0d", i), bus.m_err_o, (i == TO) ? 64'h1 : 64'h0);
      checkOutput($sformatf("to_stb_%0d", i), bus.s_stb_o, (i == TO) ? 64'h0 : 64'h1);
`else
      checkOutput($sformatf("to_err_%0d", i), bus.m_err_o, 64'h0);
      checkOutput($sformatf("to_stb_%0d", i), bus.s_stb_o, 64'h1);
`endif
    end

    // Reset in the middle of a transfer aborts it without a response
    cycle();
    rstn = 1'b0;
    applyStimulus(2'b01, 2'b01, 3'b001);
    cycle();
    #3;
    checkOutput("abort_grant", bus.grant_o, 64'h0);
    checkOutput("abort_ack", bus.m_ack_o, 64'h0);
    checkOutput("abort_scyc", bus.s_cyc_o, 64'h0);
    rstn = 1'b1;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wishbone_arbiter.md
WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

Interface
- REQ-001 Parameters SHALL be:
  - NUM_MASTERS, default 2, number of requesting masters (range 2..8).
  - TAGSIZE, default 2, width of the tag fields.
  - TIMEOUT_CYCLES, default 16, cycles allowed without a response.
- REQ-002 Ports SHALL be as follows (per-master buses are flat-packed, master k at slice k):
  - clk_i  in  1  clock; all logic on its rising edge.
  - rstn_i  in  1  reset; synchronous, active-low.
  - m_cyc_i  in  NUM_MASTERS  per-master cycle.
  - m_stb_i  in  NUM_MASTERS  per-master strobe.
  - m_we_i  in  NUM_MASTERS  per-master write enable.
  - m_sel_i  in  4*NUM_MASTERS  per-master byte select.
  - m_adr_i  in  32*NUM_MASTERS  per-master address.
  - m_dat_i  in  32*NUM_MASTERS  per-master write data.
  - m_tga_i, m_tgd_i, m_tgc_i  in  TAGSIZE*NUM_MASTERS  per-master tags.
  - m_dat_o  out  32  read data, broadcast to all masters.
  - m_tgd_o  out  TAGSIZE  read tag, broadcast.
  - m_ack_o, m_err_o, m_rty_o  out  NUM_MASTERS  per-master responses.
  - s_cyc_o, s_stb_o, s_we_o  out  1  to slave.
  - s_sel_o  out  4  to slave.
  - s_adr_o, s_dat_o  out  32  to slave.
  - s_tga_o, s_tgd_o, s_tgc_o  out  TAGSIZE  to slave.
  - s_dat_i  in  32  slave read data.
  - s_tgd_i  in  TAGSIZE  slave read tag.
  - s_ack_i, s_err_i, s_rty_i  in  1  slave responses.
  - grant_o  out  NUM_MASTERS  one-hot current grant (zero when idle).

Function
- REQ-003 FSM SHALL have two states, IDLE and GRANT, and reset to IDLE.
- REQ-004 In IDLE with any m_cyc_i high: select the first requester searching from (last_grant+1) mod NUM_MASTERS upward with wrap; register grant; enter GRANT next cycle.
  - Arbitration latency is exactly 1 cycle.
- REQ-005 In IDLE, grant_o SHALL be 0, s_cyc_o and s_stb_o SHALL be 0, and all m_ack_o/m_err_o/m_rty_o SHALL be 0.
- REQ-006 In GRANT, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o and the s_tg*_o tags SHALL combinationally equal the granted master's slice.
- REQ-007 In GRANT, the slave's ack/err/rty SHALL route combinationally to the granted master's bit only; all other masters' response bits SHALL be 0.
- REQ-008 m_dat_o/m_tgd_o SHALL equal s_dat_i/s_tgd_i at all times.
- REQ-009 Grant SHALL be held while the granted master keeps m_cyc_i high, including burst and multi-beat transfers; requests from other masters are ignored.
- REQ-010 When the granted master deasserts m_cyc_i: s_cyc_o drops the same cycle, last_grant is updated to that master, and the FSM returns to IDLE.
  - At least one IDLE cycle SHALL separate consecutive grants.
- REQ-011 Simultaneous requests SHALL be resolved by round-robin order only; a master that was just served has lowest priority next.
- REQ-012 A request withdrawn while in IDLE before the grant registers SHALL be ignored; the search uses the m_cyc_i values present in that IDLE cycle.
- REQ-013 last_grant SHALL reset to NUM_MASTERS-1 so that master 0 wins the first contention.

Reset
- REQ-014 On rstn_i low at a rising edge:
  - FSM enters IDLE.
  - grant and timeout counter clear.
  - last_grant is set to NUM_MASTERS-1.
  - From the next cycle all outputs except m_dat_o/m_tgd_o are 0.
- REQ-015 Reset asserted mid-transfer SHALL abort the grant with no response issued to the master.

Configuration
- REQ-016 Macro WB_ARB_TIMEOUT_EN:
  - When defined: a counter SHALL count GRANT cycles with s_stb_o high and no s_ack_i/s_err_i/s_rty_i. On the cycle it reaches TIMEOUT_CYCLES, the arbiter SHALL pulse m_err_o of the granted master for 1 cycle, deassert s_stb_o that cycle, and clear the counter. The counter also clears on any response or on leaving GRANT.
  - When undefined: there is no counter, and the arbiter never generates m_err_o on its own.

Verification
- REQ-017 A bench SHALL cover these directed scenarios:
  - Reset: rstn_i low 2 cycles while m_cyc_i=2'b11 -> grant_o=0, s_cyc_o=0; the cycle after release is IDLE, and the following cycle grant_o=2'b01.
  - Round robin: both masters request continuously, each drops cyc after 1 ack -> grant_o sequence 01,00,10,00,01.
  - Burst hold: master 1 holds cyc for 4 acks while master 0 requests -> grant_o=10 throughout; m_ack_o[0]=0 throughout.
  - Routing: master 1 writes adr 0x0000_1000, dat 0xDEAD_BEEF, sel 4'hF -> slave sees identical values; s_ack_i routes to m_ack_o=2'b10.
  - Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): slave never responds -> m_err_o[granted]=1 for exactly 1 cycle, 16 cycles after stb.
  - Retry: s_rty_i=1 -> m_rty_o pulses for the granted master only; grant is retained while cyc stays high.
